// File: rtl/bram_port_arbiter_if.sv
// Requester-side bus of bram_port_arbiter: per-requester command valid/ready
// with packed payloads, plus the one-hot read-response pulse and shared data.
interface bram_port_arbiter_if #(
  parameter int NREQ = 2,
  parameter int DW   = 32,
  parameter int AW   = 10
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port among NREQ requesters; read data returns in issue order.
// Optional feature: define BRAM_ARB_WRACK_EN to also pulse rsp_valid for every accepted write.
module bram_port_arbiter #(
  parameter int NREQ   = 2,
  parameter int DW     = 32,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2
) (
  input  logic                     clka,
  input  logic                     rstb,
  bram_port_arbiter_if.slave       bus,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [$clog2(DEPTH)-1:0] ram_addr,
  output logic [DW-1:0]            ram_din,
  input  logic [DW-1:0]            ram_dout,
  output logic                     ram_regce,
  output logic                     ram_rst
);
  localparam int AW  = $clog2(DEPTH);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  idx;
  logic            grant_any;
  logic [NREQ-1:0] grant;
  logic            accept;
  logic [IDW-1:0]  ram_id;

  logic [RD_LAT-1:0] tag_vld;
  logic [RD_LAT-1:0] tag_rd;
  logic [IDW-1:0]    tag_id [RD_LAT];
  logic              push_vld;
  logic              push_rd;

  logic [NREQ-1:0] rsp_valid_q;
  logic [DW-1:0]   rsp_rdata_q;

  function automatic int wrap(input int v);
    return (v >= NREQ) ? v - NREQ : v;
  endfunction

  // Search from rr_ptr upward; scanning high-to-low offsets lets the lowest offset win.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'(wrap(int'(rr_ptr) + k));
      if (bus.req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx;
      end
    end
    grant = '0;
    if (grant_any && !rstb)
      grant[grant_id] = 1'b1;
  end

  assign accept        = grant_any & ~rstb;
  assign bus.req_ready = grant;

  always_ff @(posedge clka) begin
    if (rstb) begin
      rr_ptr   <= '0;
      ram_en   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      ram_id   <= '0;
    end else begin
      ram_en <= accept;
      if (accept) begin
        rr_ptr   <= (int'(grant_id) == NREQ - 1) ? '0 : grant_id + IDW'(1);
        ram_we   <= bus.req_we[grant_id];
        ram_addr <= bus.req_addr[int'(grant_id) * AW +: AW];
        ram_din  <= bus.req_wdata[int'(grant_id) * DW +: DW];
        ram_id   <= grant_id;
      end
    end
  end

  assign push_rd = ram_en & ~ram_we;
`ifdef BRAM_ARB_WRACK_EN
  assign push_vld = ram_en;
`else
  assign push_vld = push_rd;
`endif

  // Tag shift register tracks which requester owns the data emerging from the RAM.
  always_ff @(posedge clka) begin
    if (rstb) begin
      tag_vld <= '0;
      tag_rd  <= '0;
      for (int i = 0; i < RD_LAT; i++)
        tag_id[i] <= '0;
    end else begin
      tag_vld[0] <= push_vld;
      tag_rd[0]  <= push_rd;
      tag_id[0]  <= ram_id;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_rd[i]  <= tag_rd[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  always_ff @(posedge clka) begin
    if (rstb) begin
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= '0;
      if (tag_vld[RD_LAT-1])
        rsp_valid_q[tag_id[RD_LAT-1]] <= 1'b1;
      if (tag_vld[RD_LAT-1] && tag_rd[RD_LAT-1])
        rsp_rdata_q <= ram_dout;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign ram_regce     = 1'b1;
  assign ram_rst       = rstb;

  // Structural guarantees the requesters rely on.
  ready_onehot0: assert property (@(posedge clka) $onehot0(bus.req_ready));
  rsp_onehot0:   assert property (@(posedge clka) $onehot0(bus.rsp_valid));
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter (NREQ=4, RD_LAT=2) with a behavioural RAM and
// a transaction-level reference model of arbitration, memory contents and response timing.
`timescale 1ns/1ps
module tb_bram_port_arbiter;
  localparam int NREQ   = 4;
  localparam int DW     = 32;
  localparam int DEPTH  = 1024;
  localparam int AW     = 10;
  localparam int RD_LAT = 2;
  localparam int LAT    = 1 + RD_LAT + 1;

  logic clka = 1'b0;
  logic rstb = 1'b1;
  always #5 clka = ~clka;

  bram_port_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus();

  logic          ram_en, ram_we, ram_regce, ram_rst;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  bram_port_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clka(clka), .rstb(rstb), .bus(bus),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_regce(ram_regce), .ram_rst(ram_rst)
  );

  // Behavioural BRAM port with a read latch plus output register.
  logic [DW-1:0] ram_mem [DEPTH];
  logic [DW-1:0] ram_lat;
  always @(posedge clka) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_din;
      else        ram_lat <= ram_mem[ram_addr];
    end
    if (ram_rst)        ram_dout <= '0;
    else if (ram_regce) ram_dout <= ram_lat;
  end

  typedef struct {
    int            due;
    int            id;
    bit            is_rd;
    logic [DW-1:0] data;
  } rsp_t;

  typedef struct packed {
    logic [NREQ-1:0] ready;
    logic [NREQ-1:0] rsp;
    logic [DW-1:0]   rdata;
    logic            dchk;
    logic            en;
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   din;
  } exp_t;

  rsp_t          exp_q[$];
  logic [DW-1:0] ref_mem [DEPTH];
  int            ref_ptr = 0;
  int            cyc = 0;
  bit            nxt_en = 1'b0, nxt_we = 1'b0;
  logic [AW-1:0] nxt_addr = '0;
  logic [DW-1:0] nxt_din = '0;

  logic [NREQ-1:0] pend_v = '0;
  logic [NREQ-1:0] pend_we = '0;
  logic [AW-1:0]   pend_addr [NREQ];
  logic [DW-1:0]   pend_wd [NREQ];

  int checks = 0;
  int failures = 0;
  exp_t e;

  task automatic post(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend_v[i] = 1'b1; pend_we[i] = we; pend_addr[i] = a; pend_wd[i] = d;
  endtask

  task automatic drive_bus();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]             = pend_v[i];
      bus.req_we[i]                = pend_we[i];
      bus.req_addr[i*AW +: AW]     = pend_addr[i];
      bus.req_wdata[i*DW +: DW]    = pend_wd[i];
    end
  endtask

  // One clock of the reference model: round-robin pick among pending requesters,
  // memory updated on accept, responses due LAT cycles after their accept.
  task automatic model_step(output exp_t ex);
    ex = '0;
    ex.en = nxt_en; ex.we = nxt_we; ex.addr = nxt_addr; ex.din = nxt_din;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      ex.rsp[exp_q[0].id] = 1'b1;
      ex.dchk  = exp_q[0].is_rd;
      ex.rdata = exp_q[0].data;
      void'(exp_q.pop_front());
    end
    nxt_en = 1'b0;
    if (rstb) begin
      exp_q.delete();
      ref_ptr = 0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (ref_ptr + k) % NREQ;
        if (pend_v[i]) begin
          ex.ready[i] = 1'b1;
          ref_ptr  = (i + 1) % NREQ;
          nxt_en   = 1'b1;
          nxt_we   = pend_we[i];
          nxt_addr = pend_addr[i];
          nxt_din  = pend_wd[i];
          if (pend_we[i]) begin
            ref_mem[pend_addr[i]] = pend_wd[i];
`ifdef BRAM_ARB_WRACK_EN
            exp_q.push_back('{due: cyc + LAT, id: i, is_rd: 1'b0, data: '0});
`endif
          end else begin
            exp_q.push_back('{due: cyc + LAT, id: i, is_rd: 1'b1, data: ref_mem[pend_addr[i]]});
          end
          pend_v[i] = 1'b0;
          break;
        end
      end
    end
    cyc++;
  endtask

  task automatic test_reset();
    rstb = 1'b1;
    for (int i = 0; i < NREQ; i++) post(i, 1'b1, AW'(10'h100 + i), $urandom);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) rstb = 1'b0;
      drive_bus();
      @(negedge clka);
      model_step(e);
      checks++; if (bus.req_ready !== e.ready) begin failures++; $display("[TB] FAIL reset.ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, e.ready); end
      checks++; if (bus.rsp_valid !== e.rsp) begin failures++; $display("[TB] FAIL reset.rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, e.rsp); end
      checks++; if (ram_en !== e.en) begin failures++; $display("[TB] FAIL reset.ram_en cyc=%0d got=%b exp=%b", cyc, ram_en, e.en); end
      if (e.en) begin checks++; if ({ram_we, ram_addr, ram_din} !== {e.we, e.addr, e.din}) begin failures++; $display("[TB] FAIL reset.ram_cmd cyc=%0d got=%b/%h/%h exp=%b/%h/%h", cyc, ram_we, ram_addr, ram_din, e.we, e.addr, e.din); end end
      @(posedge clka); #1;
    end
  endtask

  task automatic test_write_read();
    for (int c = 0; c < 10; c++) begin
      if (c == 0) post(1, 1'b1, 10'h005, 32'hDEADBEEF);
      if (c == 2) post(1, 1'b0, 10'h005, '0);
      drive_bus();
      @(negedge clka);
      model_step(e);
      checks++; if (bus.req_ready !== e.ready) begin failures++; $display("[TB] FAIL wr_rd.ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, e.ready); end
      checks++; if (bus.rsp_valid !== e.rsp) begin failures++; $display("[TB] FAIL wr_rd.rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, e.rsp); end
      if (e.dchk) begin checks++; if (bus.rsp_rdata !== e.rdata) begin failures++; $display("[TB] FAIL wr_rd.rdata cyc=%0d got=%h exp=%h", cyc, bus.rsp_rdata, e.rdata); end end
      checks++; if (ram_en !== e.en) begin failures++; $display("[TB] FAIL wr_rd.ram_en cyc=%0d got=%b exp=%b", cyc, ram_en, e.en); end
      if (e.en) begin checks++; if ({ram_we, ram_addr, ram_din} !== {e.we, e.addr, e.din}) begin failures++; $display("[TB] FAIL wr_rd.ram_cmd cyc=%0d got=%b/%h/%h exp=%b/%h/%h", cyc, ram_we, ram_addr, ram_din, e.we, e.addr, e.din); end end
      @(posedge clka); #1;
    end
  endtask

  task automatic test_round_robin();
    for (int c = 0; c < 22; c++) begin
      rstb = (c == 0);
      for (int i = 0; i < NREQ; i++)
        if (!pend_v[i] && c < 17 && !(c >= 9 && i == 2)) post(i, 1'b1, AW'(10'h040 + i), $urandom);
      if (c == 9) pend_v[2] = 1'b0;
      drive_bus();
      @(negedge clka);
      model_step(e);
      checks++; if (bus.req_ready !== e.ready) begin failures++; $display("[TB] FAIL rr.ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, e.ready); end
      checks++; if (bus.rsp_valid !== e.rsp) begin failures++; $display("[TB] FAIL rr.rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, e.rsp); end
      checks++; if (ram_en !== e.en) begin failures++; $display("[TB] FAIL rr.ram_en cyc=%0d got=%b exp=%b", cyc, ram_en, e.en); end
      @(posedge clka); #1;
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 20; c++) begin
      if (c == 0) begin post(0, 1'b1, 10'h010, 32'h11); post(1, 1'b1, 10'h020, 32'h22); end
      if (c >= 2 && c < 14) begin
        if (!pend_v[0]) post(0, 1'b0, 10'h010, '0);
        if (!pend_v[1]) post(1, 1'b0, 10'h020, '0);
      end
      drive_bus();
      @(negedge clka);
      model_step(e);
      checks++; if (bus.req_ready !== e.ready) begin failures++; $display("[TB] FAIL b2b.ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, e.ready); end
      checks++; if (bus.rsp_valid !== e.rsp) begin failures++; $display("[TB] FAIL b2b.rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, e.rsp); end
      if (e.dchk) begin checks++; if (bus.rsp_rdata !== e.rdata) begin failures++; $display("[TB] FAIL b2b.rdata cyc=%0d got=%h exp=%h", cyc, bus.rsp_rdata, e.rdata); end end
      @(posedge clka); #1;
    end
  endtask

  task automatic test_read_after_write();
    logic [DW-1:0] d;
    d = $urandom;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) post(2, 1'b1, 10'h200, d);
      if (c == 1) post(3, 1'b0, 10'h200, '0);
      drive_bus();
      @(negedge clka);
      model_step(e);
      checks++; if (bus.req_ready !== e.ready) begin failures++; $display("[TB] FAIL raw.ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, e.ready); end
      checks++; if (bus.rsp_valid !== e.rsp) begin failures++; $display("[TB] FAIL raw.rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, e.rsp); end
      if (e.dchk) begin checks++; if (bus.rsp_rdata !== e.rdata) begin failures++; $display("[TB] FAIL raw.rdata cyc=%0d got=%h exp=%h", cyc, bus.rsp_rdata, e.rdata); end end
      @(posedge clka); #1;
    end
  endtask

  task automatic test_reset_midflight();
    for (int c = 0; c < 20; c++) begin
      if (c == 0) begin post(0, 1'b0, 10'h010, '0); post(1, 1'b0, 10'h020, '0); end
      if (c == 3) rstb = 1'b1;
      if (c == 5) rstb = 1'b0;
      if (c == 10) post(0, 1'b0, 10'h010, '0);
      drive_bus();
      @(negedge clka);
      model_step(e);
      checks++; if (bus.req_ready !== e.ready) begin failures++; $display("[TB] FAIL midrst.ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, e.ready); end
      checks++; if (bus.rsp_valid !== e.rsp) begin failures++; $display("[TB] FAIL midrst.rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, e.rsp); end
      if (e.dchk) begin checks++; if (bus.rsp_rdata !== e.rdata) begin failures++; $display("[TB] FAIL midrst.rdata cyc=%0d got=%h exp=%h", cyc, bus.rsp_rdata, e.rdata); end end
      checks++; if (ram_en !== e.en) begin failures++; $display("[TB] FAIL midrst.ram_en cyc=%0d got=%b exp=%b", cyc, ram_en, e.en); end
      @(posedge clka); #1;
    end
  endtask

  task automatic test_write_ack();
    for (int c = 0; c < 8; c++) begin
      if (c == 0) post(0, 1'b1, 10'h300, $urandom);
      drive_bus();
      @(negedge clka);
      model_step(e);
      checks++; if (bus.req_ready !== e.ready) begin failures++; $display("[TB] FAIL wrack.ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, e.ready); end
      checks++; if (bus.rsp_valid !== e.rsp) begin failures++; $display("[TB] FAIL wrack.rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, e.rsp); end
      @(posedge clka); #1;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 420; c++) begin
      if (c < 16) post(c % NREQ, 1'b1, AW'(10'h380 + c), $urandom);
      else if (c < 400) begin
        for (int i = 0; i < NREQ; i++) begin
          if (pend_v[i] && $urandom_range(0, 15) == 0) pend_v[i] = 1'b0;
          else if (!pend_v[i] && $urandom_range(0, 2) != 0)
            post(i, 1'($urandom_range(0, 1)), AW'(10'h380 + $urandom_range(0, 15)), $urandom);
        end
      end
      drive_bus();
      @(negedge clka);
      model_step(e);
      checks++; if (bus.req_ready !== e.ready) begin failures++; $display("[TB] FAIL rand.ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, e.ready); end
      checks++; if (bus.rsp_valid !== e.rsp) begin failures++; $display("[TB] FAIL rand.rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, e.rsp); end
      if (e.dchk) begin checks++; if (bus.rsp_rdata !== e.rdata) begin failures++; $display("[TB] FAIL rand.rdata cyc=%0d got=%h exp=%h", cyc, bus.rsp_rdata, e.rdata); end end
      checks++; if (ram_en !== e.en) begin failures++; $display("[TB] FAIL rand.ram_en cyc=%0d got=%b exp=%b", cyc, ram_en, e.en); end
      if (e.en) begin checks++; if ({ram_we, ram_addr, ram_din} !== {e.we, e.addr, e.din}) begin failures++; $display("[TB] FAIL rand.ram_cmd cyc=%0d got=%b/%h/%h exp=%b/%h/%h", cyc, ram_we, ram_addr, ram_din, e.we, e.addr, e.din); end end
      @(posedge clka); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin pend_addr[i] = '0; pend_wd[i] = '0; end
    drive_bus();
    repeat (2) @(posedge clka);
    #1;
    test_reset();
    test_write_read();
    test_round_robin();
    test_back_to_back();
    test_read_after_write();
    test_reset_midflight();
    test_write_ack();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Round-robin arbiter that shares one port of the team's dual-port block RAM between NREQ independent requesters.
- Accepts read/write commands over valid/ready, registers the winning command onto the RAM port, and routes read data back to the originating requester after the RAM read latency.
- Sits between client engines (DMA, CSR shadow, FIFO logic) and one RAM port; the other port stays free for an unrelated clock domain.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DW, 32, RAM data width.
- DEPTH, 1024, RAM depth; AW = $clog2(DEPTH) (localparam).
- RD_LAT, 2, RAM read latency in cycles from enable to data: 1 = no output register, 2 = output register.
- IDW, localparam = max(1, $clog2(NREQ)), requester-id width.

Ports:
- clka  in  1  clock for the arbiter and the RAM port.
- rstb  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  per-requester command valid.
- req_ready  out  NREQ  per-requester command accepted (one-hot or zero).
- req_we  in  NREQ  per-requester write(1) / read(0).
- req_addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW].
- req_wdata  in  NREQ*DW  packed write data.
- rsp_valid  out  NREQ  one-hot read-data valid pulse.
- rsp_rdata  out  DW  read data, shared by all requesters.
- ram_en  out  1  RAM port enable.
- ram_we  out  1  RAM port write enable.
- ram_addr  out  AW  RAM port address.
- ram_din  out  DW  RAM port write data.
- ram_dout  in  DW  RAM port read data.
- ram_regce  out  1  RAM output register enable; constant 1.
- ram_rst  out  1  RAM output reset; equals rstb.

Behaviour:
- Reset (rstb=1 at a clka edge):
  - rr_ptr=0; command stage cleared (ram_en=0, ram_we=0, ram_addr=0, ram_din=0).
  - Read tag pipeline cleared; rsp_valid=0 and rsp_rdata=0.
  - req_ready is forced to 0 combinationally while rstb=1.
- Arbitration (combinational): grant = first i with req_valid[i], searching i = rr_ptr, rr_ptr+1, ... mod NREQ. req_ready = grant. At most one accept per cycle.
- Handshake:
  - A command is accepted when req_valid[i] & req_ready[i].
  - Requesters hold valid and payload stable until accepted. Dropping valid before accept is legal; that requester is simply not granted.
- Pointer: on accept by requester i, rr_ptr <= (i+1) mod NREQ. It does not change on idle cycles.
- Command stage: on the edge after an accept, ram_en=1 and ram_we/ram_addr/ram_din take the accepted values for exactly one cycle. With no accept, ram_en=0 and the other RAM outputs hold.
- Read path:
  - A read issued with ram_en=1, ram_we=0 pushes tag {1, id} into an RD_LAT-deep shift register.
  - At the tag output, rsp_valid[id] pulses for 1 cycle and rsp_rdata is registered from ram_dout.
  - Latency from accept edge to rsp_valid = 1 + RD_LAT + 1 cycles (4 at default RD_LAT=2).
  - rsp_rdata holds its last value when rsp_valid=0.
- Writes produce no response (unless the optional feature is enabled).
- Throughput: one command per cycle sustained. Responses return in issue order and are never back-pressured; requesters must always sink rsp_valid.
- Simultaneous requests: all NREQ valid continuously -> grants rotate strictly 0,1,...,NREQ-1,0.
- Same-address read-after-write from different requesters in consecutive cycles: the read returns the new data. Commands are serialized, so there is no port collision.
- Reset mid-operation: in-flight read tags are discarded with no rsp_valid; the RAM array contents are unaffected.

Optional Feature:
- Macro BRAM_ARB_WRACK_EN.
- Defined: a write also pushes a tag into the pipeline, and rsp_valid[id] pulses at the same latency as a read. rsp_rdata is then undefined-but-stable (holds its previous value) for write acks.
- Undefined: writes push an empty tag and generate no rsp_valid.

Test Plan:
- Reset: assert rstb with req_valid=all ones -> req_ready=0, ram_en=0, rsp_valid=0. First grant after release goes to requester 0.
- Single write then read: requester 1 writes addr 0x005 data 0xDEADBEEF, then reads 0x005 -> ram_en pulses twice, rsp_valid=2'b10 exactly 4 cycles after the read accept, rsp_rdata=0xDEADBEEF.
- Round-robin fairness (NREQ=4): all valid for 8 cycles -> accept order 0,1,2,3,0,1,2,3. Drop req 2 mid-run -> order skips 2 without losing a slot.
- Back-to-back mixed reads (NREQ=2): alternating reads of preloaded 0x010=0x11 (req0) and 0x020=0x22 (req1) each cycle -> rsp_valid alternates 01,10 every cycle with matching data, in order.
- Reset mid-flight: issue 2 reads, assert rstb 2 cycles later -> no rsp_valid appears. A subsequent read of the same address returns the correct data.
- BRAM_ARB_WRACK_EN defined: write from req0 -> rsp_valid=2'b01 4 cycles after accept. Undefined -> no pulse.
